bk_0011m: RTL and testbench



---
 rtl/bk_0011m.sv | 148 ++++++++++++++
 tb/tb_bk_0011m.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bk_0011m.sv
// rtl/bk_0011m.sv - BK-0011M parallel user port (177714 / XT5) cycle sequencer with AY-3-8910 command decoders
module bk_0011m #(
    parameter int STB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_type,
    input  logic [15:0] cmd_data,
    input  logic        cmd_last,
    output logic        cmd_ready,
    input  logic [15:0] xt5_in_pin,
    output logic [15:0] xt5_out_pin,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        nsel2,
    output logic        dout,
    output logic        nwrtbt,
    output logic        strobe,
    output logic        done,
    output logic        ay_orig_inact,
    output logic        ay_orig_laddr,
    output logic        ay_orig_wrpsg,
    output logic        ay_orig_rdpsg,
    output logic        ay_stas1_inact,
    output logic        ay_stas1_laddr,
    output logic        ay_stas1_wrpsg,
    output logic        ay_stas1_rdpsg
);

    typedef enum logic [1:0] {IDLE, SETUP, STB, HOLD} state_t;

    localparam logic [1:0]  T_WORD  = 2'b00;
    localparam logic [1:0]  T_BYTE  = 2'b01;
    localparam logic [1:0]  T_READ  = 2'b10;
    localparam logic [1:0]  T_RSVD  = 2'b11;
    localparam logic [15:0] STB_LAST  = 16'(STB_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [1:0]  type_q;
    logic        last_q;
    logic        accept;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = 16'd0;
                if (accept && cmd_type != T_RSVD)
                    state_next = SETUP;
            end
            SETUP: begin
                cnt_next   = 16'd0;
                state_next = STB;
            end
            STB: begin
                if (cnt == STB_LAST) begin
                    cnt_next   = 16'd0;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_next   = 16'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: begin
                cnt_next   = 16'd0;
                state_next = IDLE;
            end
        endcase
    end

    // Bus pins are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            type_q      <= T_WORD;
            last_q      <= 1'b0;
            nsel2       <= 1'b1;
            dout        <= 1'b0;
            nwrtbt      <= 1'b1;
            strobe      <= 1'b0;
            xt5_out_pin <= 16'd0;
            rd_data     <= 16'd0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            nsel2    <= (state_next == IDLE);
            strobe   <= (state_next == STB);
            rd_valid <= 1'b0;

            if (accept) begin
                type_q <= cmd_type;
                last_q <= cmd_last;
                if (cmd_type == T_WORD)
                    xt5_out_pin <= cmd_data;
                if (cmd_type == T_BYTE)
                    xt5_out_pin[7:0] <= cmd_data[7:0];
                if (cmd_type != T_RSVD) begin
                    dout   <= ~cmd_type[1];
                    nwrtbt <= (cmd_type != T_BYTE);
                end else if (cmd_last) begin
                    done <= 1'b1;
                end
            end

            // Pins are active-low, so the sampled value is inverted into rd_data.
            if (state == STB && state_next == HOLD && type_q == T_READ) begin
                rd_data  <= ~xt5_in_pin;
                rd_valid <= 1'b1;
            end

            if (state == HOLD && state_next == IDLE) begin
                dout   <= 1'b0;
                nwrtbt <= 1'b1;
                if (last_q)
                    done <= 1'b1;
            end
        end
    end

    assign ay_orig_laddr  = strobe & dout & ~nwrtbt;
    assign ay_orig_wrpsg  = strobe & dout & nwrtbt;
    assign ay_orig_rdpsg  = strobe & ~dout;
    assign ay_orig_inact  = ~(ay_orig_laddr | ay_orig_wrpsg | ay_orig_rdpsg);

    assign ay_stas1_laddr = strobe & dout & nwrtbt;
    assign ay_stas1_wrpsg = strobe & dout & ~nwrtbt;
    assign ay_stas1_rdpsg = strobe & ~dout & ~nsel2;
    assign ay_stas1_inact = ~(ay_stas1_laddr | ay_stas1_wrpsg | ay_stas1_rdpsg);

endmodule

// File: tb/tb_bk_0011m.sv
// tb/tb_bk_0011m.sv - scoreboard bench for bk_0011m port cycles and AY decoders
module tb_bk_0011m;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_type;
    logic [15:0] cmd_data;
    logic        cmd_last;
    logic        cmd_ready;
    logic [15:0] xt5_in_pin;
    logic [15:0] xt5_out_pin;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        nsel2, dout, nwrtbt, strobe, done;
    logic        ay_orig_inact, ay_orig_laddr, ay_orig_wrpsg, ay_orig_rdpsg;
    logic        ay_stas1_inact, ay_stas1_laddr, ay_stas1_wrpsg, ay_stas1_rdpsg;

    bk_0011m #(.STB_CYCLES(4), .HOLD_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .cmd_ready(cmd_ready), .xt5_in_pin(xt5_in_pin), .xt5_out_pin(xt5_out_pin),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .nsel2(nsel2), .dout(dout), .nwrtbt(nwrtbt), .strobe(strobe), .done(done),
        .ay_orig_inact(ay_orig_inact), .ay_orig_laddr(ay_orig_laddr),
        .ay_orig_wrpsg(ay_orig_wrpsg), .ay_orig_rdpsg(ay_orig_rdpsg),
        .ay_stas1_inact(ay_stas1_inact), .ay_stas1_laddr(ay_stas1_laddr),
        .ay_stas1_wrpsg(ay_stas1_wrpsg), .ay_stas1_rdpsg(ay_stas1_rdpsg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {dout, nwrtbt, orig{inact,laddr,wrpsg,rdpsg}, stas1{...}, xt5_out_pin} seen at strobe rise
    logic [25:0] bus_q[$];
    logic [15:0] rd_q[$];
    int checks = 0;
    int errors = 0;

    logic [3:0] orig_v, stas_v;
    assign orig_v = {ay_orig_inact, ay_orig_laddr, ay_orig_wrpsg, ay_orig_rdpsg};
    assign stas_v = {ay_stas1_inact, ay_stas1_laddr, ay_stas1_wrpsg, ay_stas1_rdpsg};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a strobe or a read result.
    int   stb_len = 0;
    int   low_len = 0;
    logic strobe_q = 1'b0;
    logic nsel2_q = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            stb_len  = 0;
            low_len  = 0;
            strobe_q = 1'b0;
            nsel2_q  = 1'b1;
        end else begin
            chk("orig_onehot", 32'($onehot(orig_v)), 32'd1);
            chk("stas1_onehot", 32'($onehot(stas_v)), 32'd1);
            if (strobe && !strobe_q) begin
                if (bus_q.size() == 0)
                    chk("unexpected_strobe", 32'd1, 32'd0);
                else
                    chk("bus_cycle", 32'({dout, nwrtbt, orig_v, stas_v, xt5_out_pin}),
                        32'(bus_q.pop_front()));
            end
            if (strobe) stb_len++;
            else if (strobe_q) begin
                chk("strobe_len", 32'(stb_len), 32'd4);
                stb_len = 0;
            end
            if (!nsel2) low_len++;
            else if (!nsel2_q) begin
                chk("nsel2_low_len", 32'(low_len), 32'd6);
                low_len = 0;
            end
            if (rd_valid) begin
                if (rd_q.size() == 0)
                    chk("unexpected_rd_valid", 32'd1, 32'd0);
                else
                    chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
            strobe_q = strobe;
            nsel2_q  = nsel2;
        end
    end

    // Returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] t, input logic [15:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd1, 32'd0);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_data  = d;
        cmd_last  = l;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!cmd_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    int lat;
    int acc;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_data = 16'h0;
        cmd_last = 1'b0; xt5_in_pin = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_bus", 32'({nsel2, dout, nwrtbt, strobe}), 32'b1010);
        chk("rst_xt5_out", 32'(xt5_out_pin), 32'h0);
        chk("rst_rd", 32'({rd_valid, rd_data}), 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dec", 32'({orig_v, stas_v}), 32'b1000_1000);
        rst_n = 1'b1;

        // Word write 0xBEEF: orig wrpsg, stas1 laddr
        bus_q.push_back({1'b1, 1'b1, 4'b0010, 4'b0100, 16'hBEEF});
        issue(2'b00, 16'hBEEF, 1'b0);
        chk("sel_after_accept", 32'(nsel2), 32'd0);
        wait_ready(lat);
        chk("accept_to_ready", 32'(lat), 32'd6);

        // Byte write 0x3407: only low byte changes; orig laddr, stas1 wrpsg
        bus_q.push_back({1'b1, 1'b0, 4'b0100, 4'b0010, 16'hBE07});
        issue(2'b01, 16'h3407, 1'b0);
        wait_ready(lat);

        // Byte write 0x0007 then word write 0x00A5
        bus_q.push_back({1'b1, 1'b0, 4'b0100, 4'b0010, 16'hBE07});
        issue(2'b01, 16'h0007, 1'b0);
        wait_ready(lat);
        bus_q.push_back({1'b1, 1'b1, 4'b0010, 4'b0100, 16'h00A5});
        issue(2'b00, 16'h00A5, 1'b0);
        wait_ready(lat);

        // Read with active-low pins
        xt5_in_pin = ~16'hABCD;
        bus_q.push_back({1'b0, 1'b1, 4'b0001, 4'b0001, 16'h00A5});
        rd_q.push_back(16'hABCD);
        issue(2'b10, 16'hFFFF, 1'b0);
        wait_ready(lat);
        chk("read_no_done", 32'(done), 32'd0);

        // Held cmd_valid: one accept per 7-clock slot
        bus_q.push_back({1'b1, 1'b1, 4'b0010, 4'b0100, 16'h5555});
        bus_q.push_back({1'b1, 1'b1, 4'b0010, 4'b0100, 16'h5555});
        acc = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = 2'b00; cmd_data = 16'h5555;
        for (int i = 0; i < 14; i++) begin
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("busy_accepts", 32'(acc), 32'd2);
        wait_ready(lat);

        // Read marked last sets done on HOLD exit, sticky afterwards
        xt5_in_pin = ~16'h1234;
        bus_q.push_back({1'b0, 1'b1, 4'b0001, 4'b0001, 16'h5555});
        rd_q.push_back(16'h1234);
        issue(2'b10, 16'h0, 1'b1);
        chk("done_before_exit", 32'(done), 32'd0);
        wait_ready(lat);
        chk("done_on_exit", 32'(done), 32'd1);
        bus_q.push_back({1'b1, 1'b1, 4'b0010, 4'b0100, 16'h0F0F});
        issue(2'b00, 16'h0F0F, 1'b0);
        wait_ready(lat);
        chk("done_sticky", 32'(done), 32'd1);

        // Asynchronous reset mid-strobe of a read: no rd_valid may follow
        bus_q.push_back({1'b0, 1'b1, 4'b0001, 4'b0001, 16'h0F0F});
        issue(2'b10, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        chk("pre_reset_strobe", 32'(strobe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_bus", 32'({nsel2, dout, nwrtbt, strobe}), 32'b1010);
        chk("async_rst_dec", 32'({orig_v, stas_v}), 32'b1000_1000);
        chk("async_rst_done", 32'({done, rd_valid, cmd_ready}), 32'b001);
        chk("async_rst_xt5", 32'(xt5_out_pin), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Reserved no-op marked last: accepted, no bus cycle, sets done
        issue(2'b11, 16'hDEAD, 1'b1);
        chk("rsvd_done", 32'(done), 32'd1);
        chk("rsvd_idle", 32'({cmd_ready, nsel2, strobe}), 32'b110);
        chk("rsvd_xt5", 32'(xt5_out_pin), 32'h0);
        repeat (4) @(negedge clk);

        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
